// File: rtl/leaf_stream_fifo.sv
// Single-clock stream FIFO with occupancy output and a sticky overflow flag.
// The head word is read combinationally from storage, so a push into an empty FIFO is visible after one edge.
module leaf_stream_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop_seen
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  cnt;
    logic              armed;
    logic              full, push, pop;

    // armed holds in_ready low until the first edge after reset release
    assign full      = (cnt == LVL_W'(DEPTH));
    assign in_ready  = armed && !full;
    assign out_valid = (cnt != '0);
    assign out_data  = mem[rd_ptr];
    assign level     = cnt;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            armed     <= 1'b0;
            drop_seen <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + LVL_W'(1);
                2'b01:   cnt <= cnt - LVL_W'(1);
                default: cnt <= cnt;
            endcase
            if (in_valid && full) drop_seen <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Scoreboard bench for leaf_stream_fifo: directed boundary cases followed by a long random run.
module tb_leaf_stream_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [2:0]    level;
    logic          drop_seen;

    leaf_stream_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .drop_seen(drop_seen)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_q[$];
    int            m_lvl = 0;
    bit            m_drop = 0;
    bit            m_armed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every word the DUT hands downstream must match the oldest accepted word
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_empty: got 0x%0h expected no word at %0t", out_data, $time);
            end else begin
                chk("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; entered and left 1 time unit after a rising edge
    task automatic cycle(input bit iv, input logic [DW-1:0] id, input bit ordy);
        bit p_push, p_pop;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(negedge clk);
        chk("level", int'(level), m_lvl);
        chk("in_ready", int'(in_ready), int'(m_armed && m_lvl != DEPTH));
        chk("out_valid", int'(out_valid), int'(m_lvl != 0));
        chk("drop_seen", int'(drop_seen), int'(m_drop));
        if (m_lvl != 0 && !ordy) chk("head", int'(out_data), int'(exp_q[0]));
        p_push = iv && m_armed && (m_lvl != DEPTH);
        p_pop  = ordy && (m_lvl != 0);
        if (p_push) exp_q.push_back(id);
        if (iv && m_lvl == DEPTH) m_drop = 1;
        m_lvl   = m_lvl + int'(p_push) - int'(p_pop);
        m_armed = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_drop_seen", int'(drop_seen), 0);
        exp_q.delete();
        m_lvl   = 0;
        m_drop  = 0;
        m_armed = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        #2;
        chk("por_level", int'(level), 0);
        chk("por_in_ready", int'(in_ready), 0);
        chk("por_out_valid", int'(out_valid), 0);
        chk("por_drop_seen", int'(drop_seen), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // first cycle after release: in_ready still low
        cycle(1'b0, 8'h00, 1'b0);

        // fill then drain
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b1, 8'h44, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("full_level", int'(level), 4);
        chk("full_head", int'(out_data), 8'h11);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // full boundary: pop while full does not admit 0x55 that cycle
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b1, 8'h44, 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        chk("bnd_level", int'(level), 3);
        chk("bnd_drop", int'(drop_seen), 1);
        cycle(1'b1, 8'h55, 1'b0);
        chk("bnd_level2", int'(level), 4);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

        // streaming across pointer wrap
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1);
        chk("stream_level", int'(level), 1);
        cycle(1'b0, 8'h00, 1'b1);

        // async reset at level 3
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        chk("pre_rst_level", int'(level), 3);
        do_reset();
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("post_rst_data", int'(out_data), 8'hA5);
        chk("post_rst_level", int'(level), 1);

        // random traffic
        for (int i = 0; i < 10000; i++)
            cycle(1'($urandom), 8'($urandom), 1'($urandom));

        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/leaf_stream_fifo.md
LEAF_STREAM_FIFO -- requirements
Module: leaf_stream_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-003 Ports SHALL be as follows, clock and reset first; one clock; reset is asynchronous and active-low.
- clk  input  1  sole clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word present
- in_data  input  DATA_W  upstream word
- in_ready  output  1  block accepts a word this cycle
- out_valid  output  1  word present at head
- out_data  output  DATA_W  head word
- out_ready  input  1  downstream accepts head
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- drop_seen  output  1  sticky flag: in_valid was high while full

Function
REQ-004 Push SHALL occur on a rising edge when in_valid and in_ready are both high.
REQ-005 Pop SHALL occur on a rising edge when out_valid and out_ready are both high.
REQ-006 in_ready SHALL equal (level != DEPTH); it SHALL NOT depend combinationally on out_ready.
REQ-007 out_valid SHALL equal (level != 0), and out_data SHALL be the oldest stored word.
REQ-008 Latency SHALL be one cycle: a word pushed at edge N is visible at out_data after edge N when the FIFO was empty.
REQ-009 Order SHALL be strictly first-in, first-out, with no loss or duplication of accepted words.
REQ-010 Write and read pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap.
REQ-011 level SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-012 Simultaneous push and pop SHALL be allowed at any level from 1 to DEPTH-1; at level 0 only a push is possible, and at DEPTH only a pop.
REQ-013 When full, in_ready SHALL be 0, so a simultaneous pop in that cycle SHALL NOT admit a new word; the word is admitted the following cycle.
REQ-014 drop_seen SHALL set on any edge where in_valid=1 and level=DEPTH, and SHALL remain set until reset.
REQ-015 Storage contents SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-016 in_data and out_ready SHALL be ignored while rst_n=0.

Reset
REQ-017 Assertion of rst_n low SHALL immediately, with no clock, force level=0, out_valid=0, in_ready=0, drop_seen=0, and both pointers to 0.
REQ-018 in_ready SHALL rise to 1 on the first rising edge after rst_n deasserts.
REQ-019 Reset mid-operation SHALL discard all stored words, and no stale word SHALL appear on out_valid afterwards.

Verification
REQ-020 Fill to full: push 0x11,0x22,0x33,0x44 with out_ready=0 -> level=4, in_ready=0, out_data=0x11.
REQ-021 Drain: then hold out_ready=1 for 4 cycles -> outputs 0x11,0x22,0x33,0x44 in order, then level=0 and out_valid=0.
REQ-022 Streaming: hold in_valid=1 and out_ready=1 continuously with an incrementing pattern over 20 words -> level stays at 1, one word per cycle, pointers wrap correctly.
REQ-023 Full boundary: at level=4, drive in_valid=1 with 0x55 and out_ready=1 -> 0x11 popped, level=3, 0x55 not accepted, drop_seen=1; 0x55 is accepted the next cycle with level=4.
REQ-024 Async reset: at level=3, pulse rst_n low between clock edges -> level=0, out_valid=0, drop_seen=0 immediately; after release, push 0xA5 -> out_data=0xA5 with level=1.
REQ-025 Random: run 10k cycles of random in_valid and out_ready against a reference queue model -> zero ordering mismatches, and level always equals the model depth.
